// File: rtl/debug_trace_buffer.sv
// Trace recorder for pipeline debug snapshots. It keeps a ring of recent snapshots,
// fires on a masked match against the instruction word, records a post-trigger tail,
// then streams the captured window out oldest-first over valid/ready.
module debug_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snap_valid,
    input  logic [DATA_W-1:0] snap_data,
    input  logic              arm,
    input  logic              abort,
    input  logic [31:0]       trig_value,
    input  logic [31:0]       trig_mask,
    input  logic [PTR_W-1:0]  post_cnt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [PTR_W-1:0]  trig_idx,
    output logic [1:0]        state_o
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DUMP  = 2'b11
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_pc;
    logic [PTR_W-1:0]  r_remain;
    logic [PTR_W-1:0]  r_trig_idx;
    logic [CNT_W-1:0]  r_fill;
    logic [CNT_W-1:0]  r_rd_cnt;

    logic              w_capturing;
    logic              w_wr_en;
    logic              w_match;
    logic              w_fire;
    logic [CNT_W-1:0]  w_fill_nxt;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_dump_rd_ptr;
    logic [PTR_W-1:0]  w_trig_hist;
    logic [PTR_W-1:0]  w_trig_room;
    logic [PTR_W-1:0]  w_trig_sat;

    assign w_capturing   = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_wr_en       = w_capturing && snap_valid && !abort;
    assign w_match       = snap_valid && ((snap_data[31:0] & trig_mask) == (trig_value & trig_mask));
    assign w_fire        = rd_valid && rd_ready;
    assign w_fill_nxt    = (r_fill == FULL) ? FULL : r_fill + CNT_W'(1);
    assign w_wr_ptr_nxt  = r_wr_ptr + PTR_W'(1);
    // Oldest valid entry once the current write lands; fill==DEPTH aliases to wr_ptr.
    assign w_dump_rd_ptr = w_wr_ptr_nxt - PTR_W'(w_fill_nxt);
    // Trigger position is limited by history so far and by the room left for the tail.
    assign w_trig_hist   = PTR_W'(w_fill_nxt - CNT_W'(1));
    assign w_trig_room   = PTR_W'(DEPTH - 1) - r_pc;
    assign w_trig_sat    = (w_trig_hist < w_trig_room) ? w_trig_hist : w_trig_room;

    assign rd_valid = (r_state == S_DUMP);
    assign rd_data  = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign rd_last  = rd_valid && (r_rd_cnt == CNT_W'(1));
    assign trig_idx = r_trig_idx;
    assign state_o  = r_state;

    // Ring storage: single write port, no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= snap_data;
        end
    end

    // Capture/readout control; abort overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pc       <= '0;
            r_remain   <= '0;
            r_trig_idx <= '0;
            r_fill     <= '0;
            r_rd_cnt   <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state  <= S_ARMED;
                        r_wr_ptr <= '0;
                        r_fill   <= '0;
                        r_pc     <= post_cnt;
                    end
                end
                S_ARMED: begin
                    if (snap_valid) begin
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_fill   <= w_fill_nxt;
                        if (w_match) begin
                            r_trig_idx <= w_trig_sat;
                            if (r_pc == '0) begin
                                r_state  <= S_DUMP;
                                r_rd_ptr <= w_dump_rd_ptr;
                                r_rd_cnt <= w_fill_nxt;
                            end else begin
                                r_state  <= S_POST;
                                r_remain <= r_pc;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (snap_valid) begin
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_fill   <= w_fill_nxt;
                        r_remain <= r_remain - PTR_W'(1);
                        if (r_remain == PTR_W'(1)) begin
                            r_state  <= S_DUMP;
                            r_rd_ptr <= w_dump_rd_ptr;
                            r_rd_cnt <= w_fill_nxt;
                        end
                    end
                end
                S_DUMP: begin
                    if (w_fire) begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                        r_rd_cnt <= r_rd_cnt - CNT_W'(1);
                        if (r_rd_cnt == CNT_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Bench for debug_trace_buffer: directed scenarios plus randomized captures, checked
// against a window model built from the list of valid snapshots.
module tb_debug_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;
    localparam int PTR_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              snap_valid;
    logic [DATA_W-1:0] snap_data;
    logic              arm;
    logic              abort;
    logic [31:0]       trig_value;
    logic [31:0]       trig_mask;
    logic [PTR_W-1:0]  post_cnt;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [PTR_W-1:0]  trig_idx;
    logic [1:0]        state_o;

    debug_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .arm        (arm),
        .abort      (abort),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .post_cnt   (post_cnt),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .trig_idx   (trig_idx),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] s_data[$];
    bit          s_valid[$];
    logic [63:0] exp_q[$];
    int          exp_tidx;
    int          dump_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Stimulus list: low word = index n, upper word random.
    task automatic build_directed(input int n, input bit odd_only);
        s_data.delete();
        s_valid.delete();
        for (int i = 0; i < n; i++) begin
            s_data.push_back({$urandom, 32'(i)});
            s_valid.push_back(odd_only ? (i % 2 == 1) : 1'b1);
        end
    endtask

    // Window model: first matching valid snapshot, pc more valid ones, keep the last DEPTH.
    task automatic compute_model(input int pc, input logic [31:0] val, input logic [31:0] mask);
        int vidx[$];
        int k;
        int e;
        int st;
        logic [63:0] d;
        exp_q.delete();
        k = -1;
        foreach (s_valid[i]) if (s_valid[i]) vidx.push_back(i);
        foreach (vidx[j]) begin
            d = s_data[vidx[j]];
            if (k < 0 && ((d[31:0] & mask) == (val & mask))) k = j;
        end
        e = k + pc;
        check("model_setup", 64'(k >= 0 && e < vidx.size()), 64'(1));
        if (k < 0 || e >= vidx.size()) begin
            k = 0;
            e = 0;
        end
        st = (e + 1 > DEPTH) ? e + 1 - DEPTH : 0;
        for (int j = st; j <= e; j++) exp_q.push_back(s_data[vidx[j]]);
        exp_tidx = k - st;
        dump_idx = vidx[e];
    endtask

    // Arm with a same-cycle snapshot that would match; it must not be recorded.
    task automatic do_arm(input int pc, input logic [31:0] val, input logic [31:0] mask);
        trig_value = val;
        trig_mask  = mask;
        post_cnt   = PTR_W'(pc);
        arm        = 1'b1;
        snap_valid = 1'b1;
        snap_data  = {$urandom, val};
        @(posedge clk);
        @(negedge clk);
        arm        = 1'b0;
        snap_valid = 1'b0;
        check("armed_state", 64'(state_o), 64'(1));
    endtask

    task automatic feed();
        for (int i = 0; i <= dump_idx; i++) begin
            snap_valid = s_valid[i];
            snap_data  = s_data[i];
            arm        = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            @(negedge clk);
            check("capture_rd_valid", 64'(rd_valid), 64'(i == dump_idx));
        end
        snap_valid = 1'b0;
        arm        = 1'b0;
        check("dump_state", 64'(state_o), 64'(3));
        check("trig_idx", 64'(trig_idx), 64'(exp_tidx));
    endtask

    task automatic drain(input int mode);
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        while (beat < exp_q.size() && cyc < 200) begin
            check("rd_valid", 64'(rd_valid), 64'(1));
            check("rd_data", rd_data, exp_q[beat]);
            check("rd_last", 64'(rd_last), 64'(beat == exp_q.size() - 1));
            check("trig_idx_hold", 64'(trig_idx), 64'(exp_tidx));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready   = rdy;
            snap_valid = 1'($urandom_range(0, 1));
            snap_data  = {$urandom, $urandom};
            arm        = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        check("beats_read", 64'(beat), 64'(exp_q.size()));
        rd_ready   = 1'b0;
        snap_valid = 1'b0;
        arm        = 1'b0;
        check("rd_valid_after", 64'(rd_valid), 64'(0));
        check("state_after", 64'(state_o), 64'(0));
    endtask

    task automatic run_capture(input int pc, input logic [31:0] val, input logic [31:0] mask,
                               input int mode);
        compute_model(pc, val, mask);
        do_arm(pc, val, mask);
        feed();
        drain(mode);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] val;
        logic [31:0] mask;
        logic [63:0] d;
        int          t;
        int          pc;
        bit          seen_post;

        rst_n      = 1'b0;
        snap_valid = 1'b0;
        snap_data  = '0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig_value = '0;
        trig_mask  = '0;
        post_cnt   = '0;
        rd_ready   = 1'b0;
        #1;
        check("reset_state", 64'(state_o), 64'(0));
        check("reset_rd_valid", 64'(rd_valid), 64'(0));
        check("reset_rd_last", 64'(rd_last), 64'(0));
        check("reset_rd_data", rd_data, 64'(0));
        check("reset_trig_idx", 64'(trig_idx), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a window is being read out.
        build_directed(10, 1'b0);
        compute_model(2, 32'd3, 32'hFFFF_FFFF);
        do_arm(2, 32'd3, 32'hFFFF_FFFF);
        feed();
        check("pre_reset_rd_valid", 64'(rd_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_rd_valid", 64'(rd_valid), 64'(0));
        check("async_rst_state", 64'(state_o), 64'(0));
        check("async_rst_rd_data", rd_data, 64'(0));
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Short history: readout 0..5, trigger at position 3.
        build_directed(10, 1'b0);
        run_capture(2, 32'd3, 32'hFFFF_FFFF, 0);

        // Wrap: readout 16..23, trigger at position 4.
        build_directed(31, 1'b0);
        run_capture(3, 32'd20, 32'hFFFF_FFFF, 0);

        // Same with rd_ready 1,0,0 repeating.
        build_directed(31, 1'b0);
        run_capture(3, 32'd20, 32'hFFFF_FFFF, 1);

        // Sparse valid, mask zero: first valid snapshot triggers, single beat.
        build_directed(10, 1'b1);
        run_capture(0, 32'h1234_5678, 32'h0, 0);

        // Abort in POST together with arm; arm the following cycle starts empty.
        build_directed(20, 1'b0);
        do_arm(5, 32'd2, 32'hFFFF_FFFF);
        seen_post = 1'b0;
        for (int i = 0; i < 20 && !seen_post; i++) begin
            snap_valid = 1'b1;
            snap_data  = s_data[i];
            @(posedge clk);
            @(negedge clk);
            check("abort_no_rd_valid", 64'(rd_valid), 64'(0));
            seen_post = (state_o == 2'b10);
        end
        check("reached_post", 64'(state_o), 64'(2));
        abort      = 1'b1;
        arm        = 1'b1;
        snap_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort      = 1'b0;
        arm        = 1'b0;
        snap_valid = 1'b0;
        check("abort_state", 64'(state_o), 64'(0));
        check("abort_rd_valid", 64'(rd_valid), 64'(0));
        build_directed(10, 1'b0);
        run_capture(2, 32'd3, 32'hFFFF_FFFF, 2);

        // Randomized captures.
        for (int r = 0; r < 12; r++) begin
            s_data.delete();
            s_valid.delete();
            for (int i = 0; i < 40; i++) begin
                s_data.push_back({$urandom, $urandom});
                s_valid.push_back(i < 21 ? ($urandom_range(0, 3) != 0) : 1'b1);
            end
            t = $urandom_range(0, 19);
            s_valid[t] = 1'b1;
            d = s_data[t];
            val = d[31:0];
            case ($urandom_range(0, 2))
                0:       mask = 32'hFFFF_FFFF;
                1:       mask = 32'h0;
                default: mask = $urandom;
            endcase
            pc = $urandom_range(0, DEPTH - 1);
            run_capture(pc, val, mask, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
